player_missile_pool: RTL

//  Parametrised pool of NUM_MISSILES player missiles for the VGA game peripheral.
//  - Launches a missile on each fire-button rising edge, subject to a cooldown.
//  - Steps all flying missiles upward on a divided motion tick.
//  - Retires missiles at the screen top or on a collision hit from the alien block.
//  - Provides per-pixel activity and pixel data for the colorizer.
//  - Exports missile coordinates for collision detection.

---
 rtl/vga_game_pkg.sv | 17 +
 rtl/missile_slot.sv | 86 ++++++++
 rtl/player_missile_pool.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vga_game_pkg.sv
// Shared types and default sprite geometry for the VGA game peripheral.
package vga_game_pkg;

  localparam int unsigned COORD_W_DEF    = 12;
  localparam int unsigned STEP_DEF       = 2;
  localparam int unsigned MISSILE_W_DEF  = 2;
  localparam int unsigned MISSILE_H_DEF  = 4;
  localparam int unsigned COL_OFFSET_DEF = 15;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_FLYING = 1'b1
  } slot_state_e;

endpackage

// File: rtl/missile_slot.sv
// One missile slot: IDLE/FLYING state, position registers, motion and pixel hit test.
module missile_slot
  import vga_game_pkg::*;
#(
  parameter int unsigned COORD_W   = COORD_W_DEF,
  parameter int unsigned STEP      = STEP_DEF,
  parameter int unsigned MISSILE_W = MISSILE_W_DEF,
  parameter int unsigned MISSILE_H = MISSILE_H_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               launch,
  input  logic [COORD_W-1:0] spawn_row,
  input  logic [COORD_W-1:0] spawn_col,
  input  logic               tick,
  input  logic               hit,
  input  logic [COORD_W-1:0] pixel_row,
  input  logic [COORD_W-1:0] pixel_column,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               flying,
  output logic               active
);

  localparam int unsigned CW1 = COORD_W + 1;

  slot_state_e        r_state;
  slot_state_e        w_next_state;
  logic [COORD_W-1:0] r_row;
  logic [COORD_W-1:0] r_col;
  logic               w_at_top;
  logic               w_step;
  logic [CW1-1:0]     w_row_x;
  logic [CW1-1:0]     w_col_x;
  logic [CW1-1:0]     w_prow_x;
  logic [CW1-1:0]     w_pcol_x;

  // A row below STEP cannot move up another step without underflowing, so it retires.
  assign w_at_top = tick & (r_row < COORD_W'(STEP));
  assign w_step   = (r_state == SLOT_FLYING) & ~hit & tick & ~w_at_top;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= SLOT_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state: hit outranks tick retirement; idle slots only react to launch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SLOT_IDLE:   if (launch) w_next_state = SLOT_FLYING;
      SLOT_FLYING: if (hit || w_at_top) w_next_state = SLOT_IDLE;
      default:     w_next_state = SLOT_IDLE;
    endcase
  end

  // Position registers: load on launch, step up on tick, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if ((r_state == SLOT_IDLE) && launch) begin
      r_row <= spawn_row;
      r_col <= spawn_col;
    end else if (w_step) begin
      r_row <= r_row - COORD_W'(STEP);
    end
  end

  // Outputs: state decode and pixel coverage, widened by one bit so row+H cannot wrap.
  always_comb begin
    w_row_x  = {1'b0, r_row};
    w_col_x  = {1'b0, r_col};
    w_prow_x = {1'b0, pixel_row};
    w_pcol_x = {1'b0, pixel_column};
    flying   = (r_state == SLOT_FLYING);
    active   = flying
             & (w_row_x <= w_prow_x) & (w_prow_x < w_row_x + CW1'(MISSILE_H))
             & (w_col_x <= w_pcol_x) & (w_pcol_x < w_col_x + CW1'(MISSILE_W));
  end

  assign row = r_row;
  assign col = r_col;

endmodule

// File: rtl/player_missile_pool.sv
// Pool of player missiles: fire edge detect, cooldown, motion tick, slot allocation and outputs.
module player_missile_pool
  import vga_game_pkg::*;
#(
  parameter int unsigned NUM_MISSILES   = 8,
  parameter int unsigned COORD_W        = COORD_W_DEF,
  parameter int unsigned TICK_DIV       = 250000,
  parameter int unsigned STEP           = STEP_DEF,
  parameter int unsigned MISSILE_W      = MISSILE_W_DEF,
  parameter int unsigned MISSILE_H      = MISSILE_H_DEF,
  parameter int unsigned COL_OFFSET     = COL_OFFSET_DEF,
  parameter int unsigned COOLDOWN_TICKS = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [COORD_W-1:0]                    pixel_row,
  input  logic [COORD_W-1:0]                    pixel_column,
  input  logic [COORD_W-1:0]                    player_row,
  input  logic [COORD_W-1:0]                    player_col,
  input  logic                                  fire_btn,
  input  logic [NUM_MISSILES-1:0]               hit,
  output logic [NUM_MISSILES-1:0]               missile_active,
  output logic [3:0]                            missile_output,
  output logic [NUM_MISSILES*COORD_W-1:0]       missile_rows,
  output logic [NUM_MISSILES*COORD_W-1:0]       missile_cols,
  output logic [NUM_MISSILES-1:0]               flying,
  output logic                                  fire_dropped,
  output logic [$clog2(NUM_MISSILES+1)-1:0]     active_count
);

  localparam int unsigned TW    = $clog2(TICK_DIV);
  localparam int unsigned CD_W  = (COOLDOWN_TICKS == 0) ? 1 : $clog2(COOLDOWN_TICKS + 1);
  localparam int unsigned CNT_W = $clog2(NUM_MISSILES + 1);

  logic [TW-1:0]           r_tick_cnt;
  logic [CD_W-1:0]         r_cooldown;
  logic                    r_fire_q;
  logic                    r_fire_dropped;
  logic                    w_tick;
  logic                    w_fire_edge;
  logic                    w_launch_ok;
  logic                    w_found;
  logic [NUM_MISSILES-1:0] w_sel;
  logic [COORD_W-1:0]      w_spawn_col;

  assign w_tick      = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_fire_edge = fire_btn & ~r_fire_q;
  assign w_launch_ok = w_fire_edge & (r_cooldown == '0) & ~(&flying);
  assign w_spawn_col = player_col + COORD_W'(COL_OFFSET);

  // Motion tick divider.
  always_ff @(posedge clk) begin
    if (rst)         r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // Fire button history and rejected-edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fire_q       <= 1'b0;
      r_fire_dropped <= 1'b0;
    end else begin
      r_fire_q       <= fire_btn;
      r_fire_dropped <= w_fire_edge & ~w_launch_ok;
    end
  end

  // Launch cooldown, counted in motion ticks.
  always_ff @(posedge clk) begin
    if (rst)                               r_cooldown <= '0;
    else if (w_launch_ok)                  r_cooldown <= CD_W'(COOLDOWN_TICKS);
    else if (w_tick && r_cooldown != '0)   r_cooldown <= r_cooldown - CD_W'(1);
  end

  // Lowest-index idle slot, judged on the pre-edge state.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (!flying[i] && !w_found) begin
        w_sel[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_MISSILES; g++) begin : g_slot
    missile_slot #(
      .COORD_W   (COORD_W),
      .STEP      (STEP),
      .MISSILE_W (MISSILE_W),
      .MISSILE_H (MISSILE_H)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .launch       (w_launch_ok & w_sel[g]),
      .spawn_row    (player_row),
      .spawn_col    (w_spawn_col),
      .tick         (w_tick),
      .hit          (hit[g]),
      .pixel_row    (pixel_row),
      .pixel_column (pixel_column),
      .row          (missile_rows[g*COORD_W +: COORD_W]),
      .col          (missile_cols[g*COORD_W +: COORD_W]),
      .flying       (flying[g]),
      .active       (missile_active[g])
    );
  end

  // Flying-slot population count.
  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      active_count = active_count + CNT_W'(flying[i]);
    end
  end

  assign missile_output = (|missile_active) ? 4'hF : 4'h0;
  assign fire_dropped   = r_fire_dropped;

endmodule
